// File: rtl/gray_code_tracker.sv
// gray_code_tracker: Gray input decoder with step classification, position accumulator and sticky error
module gray_code_tracker #(
  parameter int WIDTH = 2,
  parameter int POS_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] bin_out,
  output logic             step_up,
  output logic             step_dn,
  output logic [POS_W-1:0] pos,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);
  typedef enum logic {UNLOCKED, TRACK} state_t;
  state_t state;
  logic [WIDTH-1:0] g_bin, d;
  logic trk, up_c, dn_c, bad_c;
  for (genvar i = 0; i < WIDTH; i++) begin : g_conv
    assign g_bin[i] = ^gray_in[WIDTH-1:i];
  end
  always_comb begin
    d     = g_bin - bin_out;
    trk   = en && state == TRACK;
    up_c  = trk && d == WIDTH'(1);
    dn_c  = trk && d == '1;
    bad_c = trk && d != '0 && !up_c && !dn_c;
  end
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state   <= UNLOCKED;
      bin_out <= '0;
      step_up <= 1'b0;
      step_dn <= 1'b0;
      pos     <= '0;
      locked  <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      step_up <= up_c;
      step_dn <= dn_c;
      if (en) bin_out <= g_bin;
      if (en && state == UNLOCKED) begin
        state  <= TRACK;
        locked <= 1'b1;
      end
      pos     <= up_c ? pos + POS_W'(1) : dn_c ? pos - POS_W'(1) : pos;
      err     <= bad_c | (err & ~err_clr);
      // an illegal jump on the clearing edge restarts the count at one
      err_cnt <= bad_c ? (err_clr ? ERR_W'(1) : (&err_cnt ? err_cnt : err_cnt + ERR_W'(1)))
                       : (err_clr ? '0 : err_cnt);
    end
  end
endmodule

// File: tb/tb_gray_code_tracker.sv
// tb_gray_code_tracker: scoreboard-driven directed test of gray_code_tracker (WIDTH=2, POS_W=8, ERR_W=4)
module tb_gray_code_tracker;
  logic clk = 0, res = 0, en = 0, err_clr = 0;
  logic [1:0] gray_in = 0, bin_out;
  logic step_up, step_dn, locked, err;
  logic [7:0] pos;
  logic [3:0] err_cnt;
  int checks = 0, failures = 0;

  typedef struct packed {
    logic [1:0] bin;
    logic up, dn;
    logic [7:0] pos;
    logic lk, er;
    logic [3:0] cnt;
  } exp_t;
  exp_t sb[$];

  logic [1:0] m_bin;
  logic [7:0] m_pos;
  logic [3:0] m_cnt;
  logic m_lk, m_err;

  gray_code_tracker #(.WIDTH(2), .POS_W(8), .ERR_W(4)) dut (
    .clk(clk), .res(res), .en(en), .gray_in(gray_in), .err_clr(err_clr),
    .bin_out(bin_out), .step_up(step_up), .step_dn(step_dn), .pos(pos),
    .locked(locked), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] g2b(input logic [1:0] g);
    logic [1:0] b;
    b = g;
    for (int s = 1; s < 2; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [1:0] b2g(input logic [1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_bin = 0; m_pos = 0; m_cnt = 0; m_lk = 0; m_err = 0;
  endtask

  task automatic step(input logic e, input logic [1:0] g, input logic c, input string tag);
    exp_t x;
    logic [1:0] gb, dd;
    logic bad;
    en = e; gray_in = g; err_clr = c;
    gb = g2b(g);
    dd = gb - m_bin;
    bad = 0;
    x.up = 0; x.dn = 0;
    if (e) begin
      if (m_lk) begin
        if (dd == 2'd1) begin x.up = 1; m_pos = m_pos + 8'd1; end
        else if (dd == 2'd3) begin x.dn = 1; m_pos = m_pos - 8'd1; end
        else if (dd != 2'd0) bad = 1;
      end
      m_lk = 1;
      m_bin = gb;
    end
    if (bad) begin
      m_err = 1;
      m_cnt = c ? 4'd1 : (m_cnt == 4'hf ? m_cnt : m_cnt + 4'd1);
    end else if (c) begin
      m_err = 0; m_cnt = 0;
    end
    x.bin = m_bin; x.pos = m_pos; x.lk = m_lk; x.er = m_err; x.cnt = m_cnt;
    sb.push_back(x);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      x = sb.pop_front();
      chk({tag, "_bin"}, bin_out, x.bin);
      chk({tag, "_up"}, step_up, x.up);
      chk({tag, "_dn"}, step_dn, x.dn);
      chk({tag, "_pos"}, pos, x.pos);
      chk({tag, "_locked"}, locked, x.lk);
      chk({tag, "_err"}, err, x.er);
      chk({tag, "_errcnt"}, err_cnt, x.cnt);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_bin"}, bin_out, 0);
    chk({tag, "_up"}, step_up, 0);
    chk({tag, "_dn"}, step_dn, 0);
    chk({tag, "_pos"}, pos, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_errcnt"}, err_cnt, 0);
  endtask

  task automatic do_reset();
    #2 res = 0;
    #1 model_reset();
    check_zero("reset");
    @(posedge clk); #1;
    check_zero("reset_held");
    #2 res = 1;
  endtask

  initial begin
    model_reset();
    #1 check_zero("por");
    @(posedge clk); #1;
    res = 1;
    // 1: up sequence
    step(1, 2'b00, 0, "t1_lock");
    step(1, 2'b01, 0, "t1_s1");
    step(1, 2'b11, 0, "t1_s2");
    step(1, 2'b10, 0, "t1_s3");
    step(1, 2'b00, 0, "t1_s4");
    step(1, 2'b00, 0, "t1_hold");
    // 2: down sequence from fresh lock
    do_reset();
    step(1, 2'b00, 0, "t2_lock");
    step(1, 2'b10, 0, "t2_d1");
    step(1, 2'b11, 0, "t2_d2");
    step(1, 2'b01, 0, "t2_d3");
    step(1, 2'b00, 0, "t2_d4");
    chk("t2_pos252", pos, 252);
    // 3: illegal jump then resync
    step(1, 2'b11, 0, "t3_bad");
    step(1, 2'b10, 0, "t3_up");
    // 4: full wrap and saturation
    do_reset();
    step(1, 2'b00, 0, "t4_lock");
    for (int i = 0; i < 256; i++) step(1, b2g(m_bin + 2'd1), 0, "t4_up");
    chk("t4_wrap", pos, 0);
    for (int i = 0; i < 17; i++) step(1, b2g(m_bin + 2'd2), 0, "t4_bad");
    chk("t4_sat", err_cnt, 15);
    // 5: clear collides with jump, then clean clear
    step(1, b2g(m_bin + 2'd2), 1, "t5_clr_bad");
    step(1, b2g(m_bin + 2'd1), 0, "t5_up");
    step(1, b2g(m_bin + 2'd3), 1, "t5_clr");
    step(1, b2g(m_bin), 0, "t5_idle");
    // 6: async reset mid-stream, relock, enable gating
    step(1, b2g(m_bin + 2'd1), 0, "t6_pre");
    do_reset();
    step(1, 2'b11, 0, "t6_lock");
    step(0, 2'b10, 0, "t6_en0a");
    step(0, 2'b00, 0, "t6_en0b");
    step(0, 2'b01, 0, "t6_en0c");
    step(1, 2'b10, 0, "t6_resume");
    step(1, 2'b11, 0, "t6_dn");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
